// File: rtl/gf180mcu_ocd_io_pwr_seq.sv
// GF180 IO ring power sequencer: DVDD, then VDD, then pad isolation release.
// Reverse order on shutdown; supply faults force immediate safe isolation.
module gf180mcu_ocd_io_pwr_seq #(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CW          = 11
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       EN,
    input  logic       CLR,
    input  logic       DVDD_OK,
    input  logic       VDD_OK,
    output logic       DVDD_EN,
    output logic       VDD_EN,
    output logic       ISO_N,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] STATE
);

    typedef enum logic [3:0] {
        S_OFF    = 4'd0,
        S_DV_UP  = 4'd1,
        S_V_UP   = 4'd2,
        S_REL    = 4'd3,
        S_ON     = 4'd4,
        S_DN_ISO = 4'd5,
        S_DN_V   = 4'd6,
        S_DN_DV  = 4'd7,
        S_FLT    = 4'd8
    } state_e;

    localparam logic [CW-1:0] SETTLE_N  = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TMO_M1    = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_e        state_q, state_d;
    logic [1:0]    dsync_q, vsync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          dvdd_en_q, dvdd_en_d;
    logic          vdd_en_q, vdd_en_d;
    logic          iso_n_q, iso_n_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;
    logic          dok, vok;
    logic          settle_done, wait_done, tmo_done;
    logic          qual;

    assign dok = dsync_q[1];
    assign vok = vsync_q[1];

    assign settle_done = (cnt_q == SETTLE_N);
    assign wait_done   = (cnt_q == SETTLE_M1);
    assign tmo_done    = (tmo_q == TMO_M1);

    // Two-flop synchronizers for the asynchronous supply-good comparators
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            dsync_q <= 2'b00;
            vsync_q <= 2'b00;
        end else begin
            dsync_q <= {dsync_q[0], DVDD_OK};
            vsync_q <= {vsync_q[0], VDD_OK};
        end
    end

    // Next-state selection: fault > EN deassert > settle/timeout completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF: begin
                if (EN) state_d = S_DV_UP;
            end
            S_DV_UP: begin
                if (!EN)              state_d = S_DN_DV;
                else if (tmo_done)    state_d = S_FLT;
                else if (settle_done) state_d = S_V_UP;
            end
            S_V_UP: begin
                if (!dok)             state_d = S_FLT;
                else if (!EN)         state_d = S_DN_V;
                else if (tmo_done)    state_d = S_FLT;
                else if (settle_done) state_d = S_REL;
            end
            S_REL: begin
                if (!dok || !vok)   state_d = S_FLT;
                else if (!EN)       state_d = S_DN_ISO;
                else if (wait_done) state_d = S_ON;
            end
            S_ON: begin
                if (!dok || !vok) state_d = S_FLT;
                else if (!EN)     state_d = S_DN_ISO;
            end
            S_DN_ISO: begin
                if (wait_done) state_d = S_DN_V;
            end
            S_DN_V: begin
                if (wait_done) state_d = S_DN_DV;
            end
            S_DN_DV: begin
                if (wait_done) state_d = S_OFF;
            end
            S_FLT: begin
                if (CLR && !EN) state_d = S_OFF;
            end
            default: state_d = S_FLT;
        endcase
    end

    // Settle counter only advances while the watched supply is good
    always_comb begin
        qual  = 1'b1;
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        case (state_q)
            S_DV_UP: qual = dok;
            S_V_UP:  qual = vok;
            default: qual = 1'b1;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
            tmo_d = '0;
        end else begin
            if (!qual)                cnt_d = '0;
            else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            if (tmo_q != CNT_MAX)     tmo_d = tmo_q + CW'(1);
        end
    end

    // Output decode from the upcoming state so outputs track STATE exactly
    always_comb begin
        dvdd_en_d = 1'b0;
        vdd_en_d  = 1'b0;
        iso_n_d   = 1'b0;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            S_DV_UP: dvdd_en_d = 1'b1;
            S_V_UP: begin
                dvdd_en_d = 1'b1;
                vdd_en_d  = 1'b1;
            end
            S_REL: begin
                dvdd_en_d = 1'b1;
                vdd_en_d  = 1'b1;
                iso_n_d   = 1'b1;
            end
            S_ON: begin
                dvdd_en_d = 1'b1;
                vdd_en_d  = 1'b1;
                iso_n_d   = 1'b1;
                ready_d   = 1'b1;
            end
            S_DN_ISO: begin
                dvdd_en_d = 1'b1;
                vdd_en_d  = 1'b1;
            end
            S_DN_V:  dvdd_en_d = 1'b1;
            S_FLT:   fault_d   = 1'b1;
            default: ;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            tmo_q     <= '0;
            dvdd_en_q <= 1'b0;
            vdd_en_q  <= 1'b0;
            iso_n_q   <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            dvdd_en_q <= dvdd_en_d;
            vdd_en_q  <= vdd_en_d;
            iso_n_q   <= iso_n_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign DVDD_EN = dvdd_en_q;
    assign VDD_EN  = vdd_en_q;
    assign ISO_N   = iso_n_q;
    assign READY   = ready_q;
    assign FAULT   = fault_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_gf180mcu_ocd_io_pwr_seq.sv
// Directed bench for the IO ring power sequencer.
// Observation vector: {DVDD_EN,VDD_EN,ISO_N,READY,FAULT,STATE}.
module tb_gf180mcu_ocd_io_pwr_seq;

    logic       CLK = 1'b0;
    logic       RN = 1'b1;
    logic       EN = 1'b0;
    logic       CLR = 1'b0;
    logic       DVDD_OK = 1'b0;
    logic       VDD_OK = 1'b0;
    logic       DVDD_EN, VDD_EN, ISO_N, READY, FAULT;
    logic [3:0] STATE;
    logic [8:0] obs;

    int n_chk = 0;
    int n_fail = 0;

    gf180mcu_ocd_io_pwr_seq #(
        .SETTLE_CYC (4),
        .TIMEOUT_CYC(32),
        .CW         (11)
    ) dut (
        .CLK    (CLK),
        .RN     (RN),
        .EN     (EN),
        .CLR    (CLR),
        .DVDD_OK(DVDD_OK),
        .VDD_OK (VDD_OK),
        .DVDD_EN(DVDD_EN),
        .VDD_EN (VDD_EN),
        .ISO_N  (ISO_N),
        .READY  (READY),
        .FAULT  (FAULT),
        .STATE  (STATE)
    );

    always #5 CLK = ~CLK;

    assign obs = {DVDD_EN, VDD_EN, ISO_N, READY, FAULT, STATE};

    localparam logic [8:0] E_OFF = {5'b00000, 4'd0};
    localparam logic [8:0] E_DVU = {5'b10000, 4'd1};
    localparam logic [8:0] E_VU  = {5'b11000, 4'd2};
    localparam logic [8:0] E_REL = {5'b11100, 4'd3};
    localparam logic [8:0] E_ON  = {5'b11110, 4'd4};
    localparam logic [8:0] E_DNI = {5'b11000, 4'd5};
    localparam logic [8:0] E_DNV = {5'b10000, 4'd6};
    localparam logic [8:0] E_DND = {5'b00000, 4'd7};
    localparam logic [8:0] E_FLT = {5'b00001, 4'd8};

    // Invariants sampled mid-cycle
    always @(negedge CLK) begin
        if (RN) begin
            n_chk++;
            if ((ISO_N && !VDD_EN) || (VDD_EN && !DVDD_EN) ||
                (READY && !ISO_N) ||
                (FAULT && (DVDD_EN || VDD_EN || ISO_N))) begin
                n_fail++;
                $display("FAIL invariant: got %b", obs);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bring_up();
        bit hit;
        hit = 0;
        EN = 1'b1;
        DVDD_OK = 1'b1;
        VDD_OK = 1'b1;
        for (int i = 0; i < 60 && !hit; i++) begin
            step(1);
            if (STATE == 4'd4) hit = 1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL bring_up: got %b required ON", obs);
        end
    endtask

    task automatic test_reset();
        #2 RN = 1'b0;
        #1;
        n_chk++;
        if (obs !== E_OFF) begin
            n_fail++;
            $display("FAIL reset_async: got %b required %b", obs, E_OFF);
        end
        EN = 1'b1;
        step(2);
        n_chk++;
        if (obs !== E_OFF) begin
            n_fail++;
            $display("FAIL reset_hold: got %b required %b", obs, E_OFF);
        end
        EN = 1'b0;
        RN = 1'b1;
        step(1);
        n_chk++;
        if (obs !== E_OFF) begin
            n_fail++;
            $display("FAIL reset_idle: got %b required %b", obs, E_OFF);
        end
    endtask

    task automatic test_power_up();
        EN = 1'b1;
        DVDD_OK = 1'b0;
        VDD_OK = 1'b1;
        step(1);
        n_chk++;
        if (obs !== E_DVU) begin
            n_fail++;
            $display("FAIL pu_c1: got %b required %b", obs, E_DVU);
        end
        step(2);
        DVDD_OK = 1'b1;
        step(6);
        n_chk++;
        if (obs !== E_DVU) begin
            n_fail++;
            $display("FAIL pu_c9: got %b required %b", obs, E_DVU);
        end
        step(1);
        n_chk++;
        if (obs !== E_VU) begin
            n_fail++;
            $display("FAIL pu_c10: got %b required %b", obs, E_VU);
        end
        step(4);
        n_chk++;
        if (obs !== E_VU) begin
            n_fail++;
            $display("FAIL pu_c14: got %b required %b", obs, E_VU);
        end
        step(1);
        n_chk++;
        if (obs !== E_REL) begin
            n_fail++;
            $display("FAIL pu_c15: got %b required %b", obs, E_REL);
        end
        step(3);
        n_chk++;
        if (obs !== E_REL) begin
            n_fail++;
            $display("FAIL pu_c18: got %b required %b", obs, E_REL);
        end
        step(1);
        n_chk++;
        if (obs !== E_ON) begin
            n_fail++;
            $display("FAIL pu_c19: got %b required %b", obs, E_ON);
        end
    endtask

    task automatic test_shutdown();
        EN = 1'b0;
        step(1);
        n_chk++;
        if (obs !== E_DNI) begin
            n_fail++;
            $display("FAIL sd_iso: got %b required %b", obs, E_DNI);
        end
        step(3);
        n_chk++;
        if (obs !== E_DNI) begin
            n_fail++;
            $display("FAIL sd_iso_end: got %b required %b", obs, E_DNI);
        end
        step(1);
        n_chk++;
        if (obs !== E_DNV) begin
            n_fail++;
            $display("FAIL sd_v: got %b required %b", obs, E_DNV);
        end
        step(3);
        n_chk++;
        if (obs !== E_DNV) begin
            n_fail++;
            $display("FAIL sd_v_end: got %b required %b", obs, E_DNV);
        end
        step(1);
        n_chk++;
        if (obs !== E_DND) begin
            n_fail++;
            $display("FAIL sd_dv: got %b required %b", obs, E_DND);
        end
        step(3);
        n_chk++;
        if (obs !== E_DND) begin
            n_fail++;
            $display("FAIL sd_dv_end: got %b required %b", obs, E_DND);
        end
        step(1);
        n_chk++;
        if (obs !== E_OFF) begin
            n_fail++;
            $display("FAIL sd_off: got %b required %b", obs, E_OFF);
        end
        DVDD_OK = 1'b0;
        VDD_OK = 1'b0;
        step(3);
    endtask

    task automatic test_timeout();
        EN = 1'b1;
        step(1);
        n_chk++;
        if (obs !== E_DVU) begin
            n_fail++;
            $display("FAIL to_enter: got %b required %b", obs, E_DVU);
        end
        step(31);
        n_chk++;
        if (obs !== E_DVU) begin
            n_fail++;
            $display("FAIL to_c32: got %b required %b", obs, E_DVU);
        end
        step(1);
        n_chk++;
        if (obs !== E_FLT) begin
            n_fail++;
            $display("FAIL to_c33: got %b required %b", obs, E_FLT);
        end
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        step(1);
        n_chk++;
        if (obs !== E_FLT) begin
            n_fail++;
            $display("FAIL to_clr_en: got %b required %b", obs, E_FLT);
        end
        EN = 1'b0;
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        n_chk++;
        if (obs !== E_OFF) begin
            n_fail++;
            $display("FAIL to_clr: got %b required %b", obs, E_OFF);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] pat;
        pat = 8'b1110_1111;
        VDD_OK = 1'b1;
        EN = 1'b1;
        step(3);
        for (int i = 0; i < 8; i++) begin
            DVDD_OK = pat[7-i];
            step(1);
        end
        n_chk++;
        if (obs !== E_DVU) begin
            n_fail++;
            $display("FAIL gl_c11: got %b required %b", obs, E_DVU);
        end
        step(2);
        n_chk++;
        if (obs !== E_DVU) begin
            n_fail++;
            $display("FAIL gl_c13: got %b required %b", obs, E_DVU);
        end
        step(1);
        n_chk++;
        if (obs !== E_VU) begin
            n_fail++;
            $display("FAIL gl_c14: got %b required %b", obs, E_VU);
        end
        EN = 1'b0;
        step(1);
        n_chk++;
        if (obs !== E_DNV) begin
            n_fail++;
            $display("FAIL gl_abort: got %b required %b", obs, E_DNV);
        end
        step(8);
        n_chk++;
        if (obs !== E_OFF) begin
            n_fail++;
            $display("FAIL gl_off: got %b required %b", obs, E_OFF);
        end
    endtask

    task automatic test_brownout();
        bring_up();
        VDD_OK = 1'b0;
        step(2);
        n_chk++;
        if (obs !== E_ON) begin
            n_fail++;
            $display("FAIL bo_sync: got %b required %b", obs, E_ON);
        end
        step(1);
        n_chk++;
        if (obs !== E_FLT) begin
            n_fail++;
            $display("FAIL bo_flt: got %b required %b", obs, E_FLT);
        end
        VDD_OK = 1'b1;
        EN = 1'b0;
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        n_chk++;
        if (obs !== E_OFF) begin
            n_fail++;
            $display("FAIL bo_clr: got %b required %b", obs, E_OFF);
        end
        step(3);
    endtask

    task automatic test_reset_rerequest();
        EN = 1'b1;
        step(11);
        n_chk++;
        if (obs !== E_REL) begin
            n_fail++;
            $display("FAIL rr_rel: got %b required %b", obs, E_REL);
        end
        step(1);
        #2 RN = 1'b0;
        #1;
        n_chk++;
        if (obs !== E_OFF) begin
            n_fail++;
            $display("FAIL rr_async: got %b required %b", obs, E_OFF);
        end
        EN = 1'b0;
        step(1);
        RN = 1'b1;
        bring_up();
        EN = 1'b0;
        step(5);
        n_chk++;
        if (obs !== E_DNV) begin
            n_fail++;
            $display("FAIL rr_dnv: got %b required %b", obs, E_DNV);
        end
        EN = 1'b1;
        step(4);
        n_chk++;
        if (obs !== E_DND) begin
            n_fail++;
            $display("FAIL rr_dndv: got %b required %b", obs, E_DND);
        end
        step(4);
        n_chk++;
        if (obs !== E_OFF) begin
            n_fail++;
            $display("FAIL rr_off: got %b required %b", obs, E_OFF);
        end
        step(1);
        n_chk++;
        if (obs !== E_DVU) begin
            n_fail++;
            $display("FAIL rr_restart: got %b required %b", obs, E_DVU);
        end
        EN = 1'b0;
        step(14);
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_shutdown();
        test_timeout();
        test_glitch();
        test_brownout();
        test_reset_rerequest();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
